// File: rtl/hmm_gen_alpha_pkg.sv
// Shared types and fixed-point helpers for the HMM forward engine.
// All arithmetic is unsigned, fully fractional, truncating.
package hmm_pkg;

    localparam int DEF_HIDDEN_STATES   = 4;
    localparam int DEF_OBSERVED_STATES = 4;
    localparam int DEF_OBSERVED_LEN    = 8;
    localparam int DEF_DATA_PREC       = 16;

    // Helpers work at this width; DATA_PREC must not exceed it.
    localparam int MAX_P = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    // (a*b) >> p, truncated; a and b hold p-bit values zero-extended.
    function automatic logic [MAX_P-1:0] mul(
        input logic [MAX_P-1:0] a,
        input logic [MAX_P-1:0] b,
        input int               p
    );
        return MAX_P'(({{MAX_P{1'b0}}, a} * {{MAX_P{1'b0}}, b}) >> p);
    endfunction

    // Full-width sum clamped to 2^p-1.
    function automatic logic [MAX_P-1:0] sat_add(
        input logic [MAX_P-1:0] a,
        input logic [MAX_P-1:0] b,
        input int               p
    );
        logic [MAX_P:0] s;
        logic [MAX_P:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = ((MAX_P+1)'(1) << p) - (MAX_P+1)'(1);
        return (s > lim) ? MAX_P'(lim) : MAX_P'(s);
    endfunction

    // Element index of trans[i][j] in the flattened bus.
    function automatic int trans_idx(input int i, input int j, input int h);
        return i * h + j;
    endfunction

    // Element index of emm[i][k] in the flattened bus.
    function automatic int emm_idx(input int i, input int k, input int o);
        return i * o + k;
    endfunction

    // Element index of alpha[t][j] in the flattened bus.
    function automatic int alpha_idx(input int t, input int j, input int h);
        return t * h + j;
    endfunction

endpackage

// File: rtl/hmm_gen_alpha_if.sv
// Request/result bundle of the forward engine.
// master drives the model and sequence; slave is the engine.
interface hmm_gen_alpha_if #(
    parameter int HIDDEN_STATES   = 4,
    parameter int OBSERVED_STATES = 4,
    parameter int OBSERVED_LEN    = 8,
    parameter int DATA_PREC       = 16
);
    localparam int H  = HIDDEN_STATES;
    localparam int O  = OBSERVED_STATES;
    localparam int L  = OBSERVED_LEN;
    localparam int P  = DATA_PREC;
    localparam int OW = $clog2(O);

    logic               start;
    logic [L*OW-1:0]    observed_seq;
    logic [H*H*P-1:0]   trans;
    logic [H*O*P-1:0]   emm;
    logic [H*P-1:0]     pi;
    logic [L*H*P-1:0]   alphas;
    logic [P-1:0]       alpha_sum;
    logic               busy;
    logic               done;

    modport master (
        output start, observed_seq, trans, emm, pi,
        input  alphas, alpha_sum, busy, done
    );

    modport slave (
        input  start, observed_seq, trans, emm, pi,
        output alphas, alpha_sum, busy, done
    );

endinterface

// File: rtl/hmm_gen_alpha_cell.sv
// One forward variable alpha[t][j]: weighted sum of the previous
// row (or pi on the first step) scaled by the emission probability.
module alpha_cell
    import hmm_pkg::*;
#(
    parameter  int HIDDEN_STATES   = DEF_HIDDEN_STATES,
    parameter  int OBSERVED_STATES = DEF_OBSERVED_STATES,
    parameter  int DATA_PREC       = DEF_DATA_PREC,
    localparam int OW              = $clog2(OBSERVED_STATES)
) (
    input  logic                               first,
    input  logic [DATA_PREC-1:0]               pi_j,
    input  logic [HIDDEN_STATES*DATA_PREC-1:0] prev_row,
    input  logic [HIDDEN_STATES*DATA_PREC-1:0] trans_col,
    input  logic [OBSERVED_STATES*DATA_PREC-1:0] emm_row,
    input  logic [OW-1:0]                      sym,
    output logic [DATA_PREC-1:0]               alpha
);
    localparam int H = HIDDEN_STATES;
    localparam int O = OBSERVED_STATES;
    localparam int P = DATA_PREC;

    logic [MAX_P-1:0] acc;
    logic [MAX_P-1:0] base;
    logic [MAX_P-1:0] e;
    logic             sym_ok;
    int               k;

    // Accumulate, pick pi on t=0, then apply emission (0 if symbol invalid).
    always_comb begin
        acc = '0;
        for (int i = 0; i < H; i++) begin
            acc = sat_add(acc,
                          mul(MAX_P'(prev_row[i*P +: P]),
                              MAX_P'(trans_col[i*P +: P]), P),
                          P);
        end
        base   = first ? MAX_P'(pi_j) : acc;
        sym_ok = int'(sym) < O;
        k      = sym_ok ? int'(sym) : 0;
        e      = sym_ok ? MAX_P'(emm_row[k*P +: P]) : '0;
        alpha  = P'(mul(base, e, P));
    end

endmodule

// File: rtl/hmm_gen_alpha.sv
// Sequential HMM forward engine: one alpha row per cycle, then the
// final-row sum; FSM, step counter, captured sequence and row storage.
module hmm_gen_alpha
    import hmm_pkg::*;
#(
    parameter int HIDDEN_STATES   = DEF_HIDDEN_STATES,
    parameter int OBSERVED_STATES = DEF_OBSERVED_STATES,
    parameter int OBSERVED_LEN    = DEF_OBSERVED_LEN,
    parameter int DATA_PREC       = DEF_DATA_PREC
) (
    input  logic           clk,
    input  logic           rst_n,
    hmm_gen_alpha_if.slave bus
);
    localparam int H  = HIDDEN_STATES;
    localparam int O  = OBSERVED_STATES;
    localparam int L  = OBSERVED_LEN;
    localparam int P  = DATA_PREC;
    localparam int OW = $clog2(O);
    localparam int TW = $clog2(L + 1);

    state_t           state_q;
    state_t           state_d;
    logic [TW-1:0]    t_q;
    logic [TW-1:0]    t_rd;
    logic [TW-1:0]    t_prev;
    logic [L*OW-1:0]  seq_q;
    logic [L*H*P-1:0] alphas_q;
    logic [P-1:0]     sum_q;
    logic [P-1:0]     sum_d;
    logic [MAX_P-1:0] sum_acc;
    logic             done_q;
    logic             accept;
    logic             row_we;
    logic             sum_we;
    logic             first;
    logic [OW-1:0]    sym;
    logic [H*P-1:0]   prev_row;
    logic [H*P-1:0]   row_new;

    assign accept = (state_q == IDLE) && bus.start;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: one RUN cycle per row, then a single FIN cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (t_q == TW'(L - 1)) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs and datapath strobes decoded from the state.
    always_comb begin
        row_we   = (state_q == RUN);
        sum_we   = (state_q == FIN);
        bus.busy = (state_q != IDLE);
        bus.done = done_q;
    end

    // Step counter and sequence capture on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q   <= '0;
            seq_q <= '0;
        end else if (accept) begin
            t_q   <= '0;
            seq_q <= bus.observed_seq;
        end else if (row_we) begin
            t_q   <= t_q + TW'(1);
        end
    end

    // Row addressing; t_q reaches L in FIN, so reads are kept in range.
    always_comb begin
        first    = (t_q == '0);
        t_rd     = (int'(t_q) < L) ? t_q : '0;
        t_prev   = first ? '0 : t_q - TW'(1);
        sym      = seq_q[int'(t_rd)*OW +: OW];
        prev_row = alphas_q[int'(t_prev)*H*P +: H*P];
    end

    for (genvar j = 0; j < H; j++) begin : g_cell
        logic [H*P-1:0] tcol;

        // Gather column j of the transition matrix.
        always_comb begin
            tcol = '0;
            for (int i = 0; i < H; i++) begin
                tcol[i*P +: P] = bus.trans[trans_idx(i, j, H)*P +: P];
            end
        end

        alpha_cell #(
            .HIDDEN_STATES  (H),
            .OBSERVED_STATES(O),
            .DATA_PREC      (P)
        ) u_cell (
            .first    (first),
            .pi_j     (bus.pi[j*P +: P]),
            .prev_row (prev_row),
            .trans_col(tcol),
            .emm_row  (bus.emm[emm_idx(j, 0, O)*P +: O*P]),
            .sym      (sym),
            .alpha    (row_new[j*P +: P])
        );
    end

    // Saturating sum of the final row.
    always_comb begin
        sum_acc = '0;
        for (int j = 0; j < H; j++) begin
            sum_acc = sat_add(sum_acc,
                              MAX_P'(alphas_q[alpha_idx(L - 1, j, H)*P +: P]),
                              P);
        end
        sum_d = P'(sum_acc);
    end

    // Row storage, total and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alphas_q <= '0;
            sum_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            if (row_we) alphas_q[int'(t_rd)*H*P +: H*P] <= row_new;
            if (sum_we) sum_q <= sum_d;
            done_q <= sum_we;
        end
    end

    assign bus.alphas    = alphas_q;
    assign bus.alpha_sum = sum_q;

endmodule

// File: tb/tb_hmm_gen_alpha.sv
// Directed bench for hmm_gen_alpha over three configurations:
// small uniform model, 4-state saturation, and a 3-symbol alphabet.
module tb_hmm_gen_alpha;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    hmm_gen_alpha_if #(.HIDDEN_STATES(2), .OBSERVED_STATES(2),
                       .OBSERVED_LEN(3), .DATA_PREC(16)) a_if ();
    hmm_gen_alpha_if #(.HIDDEN_STATES(4), .OBSERVED_STATES(4),
                       .OBSERVED_LEN(2), .DATA_PREC(16)) b_if ();
    hmm_gen_alpha_if #(.HIDDEN_STATES(2), .OBSERVED_STATES(3),
                       .OBSERVED_LEN(2), .DATA_PREC(16)) c_if ();

    hmm_gen_alpha #(.HIDDEN_STATES(2), .OBSERVED_STATES(2),
                    .OBSERVED_LEN(3), .DATA_PREC(16))
        u_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
    hmm_gen_alpha #(.HIDDEN_STATES(4), .OBSERVED_STATES(4),
                    .OBSERVED_LEN(2), .DATA_PREC(16))
        u_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
    hmm_gen_alpha #(.HIDDEN_STATES(2), .OBSERVED_STATES(3),
                    .OBSERVED_LEN(2), .DATA_PREC(16))
        u_c (.clk(clk), .rst_n(rst_n), .bus(c_if));

    typedef struct {
        logic [15:0] pi0, pi1, tr, e0, e1;
        logic [2:0]  seq;
        logic [15:0] r00, r01, r1, r2, sum;
    } vec_t;

    vec_t va[5];

    logic [3:0]  c_seq[4];
    logic [15:0] c_r0[4];
    logic [15:0] c_r1[4];
    logic [15:0] c_sum[4];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic logic [15:0] a_ent(input int t, input int j);
        return a_if.alphas[(t*2+j)*16 +: 16];
    endfunction

    function automatic logic [15:0] b_ent(input int t, input int j);
        return b_if.alphas[(t*4+j)*16 +: 16];
    endfunction

    function automatic logic [15:0] c_ent(input int t, input int j);
        return c_if.alphas[(t*2+j)*16 +: 16];
    endfunction

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0:       a_if.start = v;
            1:       b_if.start = v;
            default: c_if.start = v;
        endcase
    endtask

    function automatic logic done_of(input int sel);
        case (sel)
            0:       return a_if.done;
            1:       return b_if.done;
            default: return c_if.done;
        endcase
    endfunction

    function automatic logic busy_of(input int sel);
        case (sel)
            0:       return a_if.busy;
            1:       return b_if.busy;
            default: return c_if.busy;
        endcase
    endfunction

    // Start a run, optionally re-pulse start at cycle rs_at, check timing.
    task automatic run(input int sel, input int lat, input int rs_at,
                       input string tag);
        int got;
        @(negedge clk);
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        chk({tag, "_busy_start"}, 64'(busy_of(sel)), 64'd1);
        got = -1;
        for (int c = 1; c <= 20; c++) begin
            if (c == rs_at) set_start(sel, 1'b1);
            @(negedge clk);
            set_start(sel, 1'b0);
            if (done_of(sel)) begin
                got = c;
                break;
            end
        end
        chk({tag, "_latency"}, 64'(got), 64'(lat));
        if (got > 0) begin
            @(negedge clk);
            chk({tag, "_done_pulse"}, 64'(done_of(sel)), 64'd0);
            chk({tag, "_busy_drop"}, 64'(busy_of(sel)), 64'd0);
        end
    endtask

    task automatic apply_a(input vec_t v);
        a_if.pi           = {v.pi1, v.pi0};
        a_if.trans        = {4{v.tr}};
        a_if.emm          = {v.e1, v.e0, v.e1, v.e0};
        a_if.observed_seq = v.seq;
    endtask

    task automatic check_a(input vec_t v, input string tag);
        chk({tag, "_r00"}, 64'(a_ent(0, 0)), 64'(v.r00));
        chk({tag, "_r01"}, 64'(a_ent(0, 1)), 64'(v.r01));
        chk({tag, "_r10"}, 64'(a_ent(1, 0)), 64'(v.r1));
        chk({tag, "_r11"}, 64'(a_ent(1, 1)), 64'(v.r1));
        chk({tag, "_r20"}, 64'(a_ent(2, 0)), 64'(v.r2));
        chk({tag, "_r21"}, 64'(a_ent(2, 1)), 64'(v.r2));
        chk({tag, "_sum"}, 64'(a_if.alpha_sum), 64'(v.sum));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        va[0] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 3'b010,
                  16'h4000, 16'h4000, 16'h2000, 16'h1000, 16'h2000};
        va[1] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000, 3'b010,
                  16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h0000};
        va[2] = '{16'h8000, 16'h4000, 16'h4000, 16'h8000, 16'h4000, 3'b101,
                  16'h2000, 16'h1000, 16'h0600, 16'h00C0, 16'h0180};
        va[3] = '{16'h0003, 16'h0003, 16'hFFFF, 16'h8000, 16'h8000, 3'b000,
                  16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0000};
        va[4] = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'hFFFF, 16'hFFFF, 3'b000,
                  16'hFFFE, 16'hFFFE, 16'hFFFD, 16'hFFFB, 16'hFFFF};

        c_seq[0] = 4'b0000; c_r0[0] = 16'h4000; c_r1[0] = 16'h2000; c_sum[0] = 16'h4000;
        c_seq[1] = 4'b0011; c_r0[1] = 16'h0000; c_r1[1] = 16'h0000; c_sum[1] = 16'h0000;
        c_seq[2] = 4'b1010; c_r0[2] = 16'h4000; c_r1[2] = 16'h2000; c_sum[2] = 16'h4000;
        c_seq[3] = 4'b1100; c_r0[3] = 16'h4000; c_r1[3] = 16'h0000; c_sum[3] = 16'h0000;

        a_if.start = 1'b0;
        b_if.start = 1'b0;
        c_if.start = 1'b0;
        apply_a(va[0]);
        b_if.pi           = {4{16'hFFFF}};
        b_if.trans        = {16{16'hFFFF}};
        b_if.emm          = {16{16'hFFFF}};
        b_if.observed_seq = 4'b0000;
        c_if.pi           = {2{16'h8000}};
        c_if.trans        = {4{16'h8000}};
        c_if.emm          = {6{16'h8000}};
        c_if.observed_seq = 4'b0000;

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(a_if.busy), 64'd0);
        chk("rst_done", 64'(a_if.done), 64'd0);
        chk("rst_alphas", 64'(|a_if.alphas), 64'd0);
        chk("rst_sum", 64'(a_if.alpha_sum), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            apply_a(va[i]);
            run(0, 4, 0, $sformatf("a%0d", i));
            check_a(va[i], $sformatf("a%0d", i));
        end

        apply_a(va[2]);
        run(0, 4, 2, "restart");
        check_a(va[2], "restart");

        run(1, 3, 0, "sat");
        for (int t = 0; t < 2; t++) begin
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("sat_r%0d%0d", t, j), 64'(b_ent(t, j)), 64'hFFFE);
            end
        end
        chk("sat_sum", 64'(b_if.alpha_sum), 64'hFFFF);

        for (int i = 0; i < 4; i++) begin
            c_if.observed_seq = c_seq[i];
            run(2, 3, 0, $sformatf("sym%0d", i));
            for (int j = 0; j < 2; j++) begin
                chk($sformatf("sym%0d_r0%0d", i, j), 64'(c_ent(0, j)), 64'(c_r0[i]));
                chk($sformatf("sym%0d_r1%0d", i, j), 64'(c_ent(1, j)), 64'(c_r1[i]));
            end
            chk($sformatf("sym%0d_sum", i), 64'(c_if.alpha_sum), 64'(c_sum[i]));
        end

        apply_a(va[0]);
        @(negedge clk);
        a_if.start = 1'b1;
        @(negedge clk);
        a_if.start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(a_if.busy), 64'd0);
        chk("abort_done", 64'(a_if.done), 64'd0);
        chk("abort_alphas", 64'(|a_if.alphas), 64'd0);
        chk("abort_sum", 64'(a_if.alpha_sum), 64'd0);
        chk("abort_b_alphas", 64'(|b_if.alphas), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (a_if.done) pulses++;
        end
        chk("abort_no_done", 64'(pulses), 64'd0);
        chk("abort_idle", 64'(a_if.busy), 64'd0);

        apply_a(va[2]);
        run(0, 4, 0, "post_rst");
        check_a(va[2], "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hmm_gen_alpha.md
# hmm_gen_alpha

Sequential HMM forward-algorithm engine. Given an observation sequence, a transition matrix, an emission matrix and an initial distribution, it computes every forward variable alpha[t][j] in unsigned fixed point. It also computes the total sequence probability, which is the sum of the final alpha row. It sits under the HMM top level, which loads the model matrices and applies any output scaling.

## Interface
Parameters:
- HIDDEN_STATES (H), default 4: number of hidden states; must be at least 1.
- OBSERVED_STATES (O), default 4: observation alphabet size; must be at least 2.
- OBSERVED_LEN (L), default 8: sequence length; must be at least 1.
- DATA_PREC (P), default 16: data width.
- OW = $clog2(O): derived symbol width.

Ports (one clock; reset is asynchronous and active-low):
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: request a run; accepted only in IDLE.
- observed_seq, in, L*OW: symbol t at [t*OW +: OW].
- trans, in, H*H*P: element [i][j] (from i to j) at [(i*H+j)*P +: P].
- emm, in, H*O*P: element [i][k] at [(i*O+k)*P +: P].
- pi, in, H*P: initial distribution; element i at [i*P +: P].
- alphas, out, L*H*P: element [t][j] at [(t*H+j)*P +: P].
- alpha_sum, out, P: sum of alpha[L-1][*].
- busy, out, 1: run in progress.
- done, out, 1: one-cycle completion pulse.

## Operation
- Number format: unsigned, all P bits fractional, value = x/2^P.
- mul(a,b) = (a*b) >> P, truncated.
- sat_add: full-width sum, clamped to 2^P-1.
- FSM states: IDLE, RUN, FIN.
- IDLE with start=1: capture observed_seq into an internal register, set t=0, go to RUN.
- Model inputs trans, emm and pi are not captured; they must stay stable while busy.
- RUN, t=0: alpha[0][j] = mul(pi[j], E(j, o0)).
- RUN, t>0: alpha[t][j] = mul(sat_add over i of mul(alpha[t-1][i], trans[i][j]), E(j, o_t)).
- All H entries of row t are written in one cycle.
- After t = L-1, go to FIN.
- E(j,k) = emm[j][k] if k < O, else 0. Out-of-range symbols yield zero probability.
- FIN: alpha_sum <= sat_add over j of alpha[L-1][j]; assert done; return to IDLE.
- alphas rows are not cleared at start; each row is overwritten as it is computed.
- alphas and alpha_sum hold their values until overwritten or reset.
- start while busy is ignored.

## Timing
- Start accepted at edge k.
- busy = 1 after edge k; it drops after edge k+L+1.
- Row t is valid after edge k+1+t.
- alpha_sum is valid, and done is high, for exactly one cycle after edge k+L+1.
- Total latency: L+1 cycles.
- A new start may be asserted in the same cycle done is high; it is accepted at edge k+L+2 (state is IDLE by then).
- Reset values: all alphas = 0, alpha_sum = 0, busy = 0, done = 0, FSM = IDLE.
- Asserting rst_n low mid-run aborts immediately. No done pulse is produced for the aborted run.

## Structure
- Package hmm_pkg holds:
  - the default parameter constants;
  - function mul(a,b);
  - function sat_add;
  - index helper functions for the flattened buses.
- Sub-module alpha_cell: computes one alpha[t][j], i.e. H multipliers, a saturating adder tree and the emission multiply. A mux selects pi versus the previous row when t=0. It is instantiated H times in a generate loop.
- The top level holds the FSM, the t counter, the captured sequence and the alpha register file.

## Test plan
- H=2, O=2, L=3, P=16; pi, trans and emm all 0x8000; seq 0,1,0:
  - rows = {0x4000,0x4000}, {0x2000,0x2000}, {0x1000,0x1000};
  - alpha_sum = 0x2000;
  - done exactly 4 cycles after the start edge.
- Same setup but emm[*][1] = 0, seq 0,1,0: row 0 = 0x4000; rows 1 and 2 = 0; alpha_sum = 0.
- Saturation, H=4, L=2; pi, trans and emm all 0xFFFF:
  - row 0 = 0xFFFE;
  - row 1: the sum of 4 × 0xFFFD clamps to 0xFFFF, so row 1 = 0xFFFE;
  - alpha_sum = 0xFFFF.
- Symbol out of range: O=3, OW=2, seq symbol 3 at t=0 → row 0 = 0; all subsequent rows = 0.
- Pulse start again mid-run → ignored; results and timing are identical to an undisturbed run.
- Drop rst_n low mid-run → alphas, busy and done clear immediately. A fresh start then completes correctly.
